// File: rtl/sold_counter.sv
// sold_counter
//   Per-good sales tally for the vending machine. Keeps a saturating two-digit
//   BCD count for goods 1..NUM_GOODS plus a saturating two-digit BCD grand
//   total, and presents the count of the selected good to the display stage.
//
// Ports
//   clk        system clock, rising edge
//   EN         asynchronous active-low reset (clears counts, flags, FSM)
//   sell_req   sale request, level, held until sell_ack / sell_err
//   sell_good  good being sold (1..NUM_GOODS valid)
//   sell_qty   units in this sale (1..3 valid)
//   sell_ack   one-cycle pulse: sale committed
//   sell_err   one-cycle pulse: request rejected (good 0 or qty 0)
//   clr_req    clear-all request, level, held until clr_done
//   clr_done   one-cycle pulse on the last cycle of the clear sweep
//   view_good  good selected for display
//   behavior   registered copy of view_good
//   sold1/2    BCD units / tens of the viewed good's count
//   sat        viewed good's count has saturated at 99
//   total1/2   BCD units / tens of the grand total
module sold_counter #(
  parameter int NUM_GOODS = 7
) (
  input  logic       clk,
  input  logic       EN,
  input  logic       sell_req,
  input  logic [2:0] sell_good,
  input  logic [1:0] sell_qty,
  output logic       sell_ack,
  output logic       sell_err,
  input  logic       clr_req,
  output logic       clr_done,
  input  logic [2:0] view_good,
  output logic [2:0] behavior,
  output logic [3:0] sold1,
  output logic [3:0] sold2,
  output logic       sat,
  output logic [3:0] total1,
  output logic [3:0] total2
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;

  localparam logic [2:0] MAX_GOOD = 3'(NUM_GOODS);
  localparam logic [2:0] LAST_PTR = 3'd7;
  localparam logic [7:0] BCD_MAX  = 8'h99;

  logic [2:0] state_q, state_d;
  logic [2:0] good_q,  good_d;
  logic [1:0] rem_q,   rem_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q    [8];
  logic [7:0] cnt_d    [8];
  logic [7:0] satf_q, satf_d;
  logic [7:0] total_q, total_d;

  logic [2:0] behavior_q, behavior_d;
  logic [7:0] disp_q,     disp_d;
  logic       sat_q,      sat_d;

  logic       good_ok;

  // Two-digit BCD increment; callers handle the 99 ceiling.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign good_ok = (sell_good != 3'd0) && (sell_good <= MAX_GOOD);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    satf_d  = satf_q;
    total_d = total_q;

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLR;
          ptr_d   = '0;
        end else if (sell_req) begin
          if (good_ok && (sell_qty != 2'd0)) begin
            state_d = S_ADD;
            good_d  = sell_good;
            rem_d   = sell_qty;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_ADD: begin
        // One unit per cycle; an increment attempted at 99 holds and flags.
        if (cnt_q[good_q] == BCD_MAX) begin
          satf_d[good_q] = 1'b1;
        end else begin
          cnt_d[good_q] = bcd_inc(cnt_q[good_q]);
        end
        if (total_q != BCD_MAX) begin
          total_d = bcd_inc(total_q);
        end
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) begin
          state_d = S_ACK;
        end
      end

      S_ACK, S_ERR: begin
        state_d = S_IDLE;
      end

      S_CLR: begin
        cnt_d[ptr_q]  = '0;
        satf_d[ptr_q] = 1'b0;
        ptr_d         = ptr_q + 3'd1;
        if (ptr_q == LAST_PTR) begin
          total_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entry 0 is never a real good and always reads as zero.
    cnt_d[0]  = '0;
    satf_d[0] = 1'b0;
  end

  always_comb begin
    behavior_d = view_good;
    disp_d     = cnt_q[view_good];
    sat_d      = satf_q[view_good];
  end

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      state_q    <= S_IDLE;
      good_q     <= '0;
      rem_q      <= '0;
      ptr_q      <= '0;
      satf_q     <= '0;
      total_q    <= '0;
      behavior_q <= '0;
      disp_q     <= '0;
      sat_q      <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      rem_q      <= rem_d;
      ptr_q      <= ptr_d;
      satf_q     <= satf_d;
      total_q    <= total_d;
      behavior_q <= behavior_d;
      disp_q     <= disp_d;
      sat_q      <= sat_d;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sell_ack = (state_q == S_ACK);
  assign sell_err = (state_q == S_ERR);
  assign clr_done = (state_q == S_CLR) && (ptr_q == LAST_PTR);

  assign behavior = behavior_q;
  assign sold1    = disp_q[3:0];
  assign sold2    = disp_q[7:4];
  assign sat      = sat_q;
  assign total1   = total_q[3:0];
  assign total2   = total_q[7:4];

endmodule

// File: tb/tb_sold_counter.sv
module tb_sold_counter;

  logic       clk = 1'b0;
  logic       EN = 1'b0;
  logic       sell_req = 1'b0;
  logic [2:0] sell_good = '0;
  logic [1:0] sell_qty = '0;
  logic       clr_req = 1'b0;
  logic [2:0] view_good = '0;
  logic       sell_ack, sell_err, clr_done, sat;
  logic [2:0] behavior;
  logic [3:0] sold1, sold2, total1, total2;

  sold_counter #(.NUM_GOODS(7)) dut (
    .clk(clk), .EN(EN),
    .sell_req(sell_req), .sell_good(sell_good), .sell_qty(sell_qty),
    .sell_ack(sell_ack), .sell_err(sell_err),
    .clr_req(clr_req), .clr_done(clr_done),
    .view_good(view_good), .behavior(behavior),
    .sold1(sold1), .sold2(sold2), .sat(sat),
    .total1(total1), .total2(total2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  // kind: 0 = sell_ack, 1 = sell_err, 2 = clr_done
  typedef struct {
    int kind; int due; int view;
    int u; int t; int s; int tu; int tt;
  } exp_t;
  exp_t exp_q[$];

  int m_cnt[8];
  int m_sat[8];
  int m_tot;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_sat[i] = 0;
    end
    m_tot = 0;
  endfunction

  function automatic void m_sell(int g, int q);
    if (m_cnt[g] + q > 99) begin
      m_cnt[g] = 99;
      m_sat[g] = 1;
    end else begin
      m_cnt[g] = m_cnt[g] + q;
    end
    m_tot = (m_tot + q > 99) ? 99 : m_tot + q;
  endfunction

  function automatic void push(int kind, int due, int v);
    exp_t e;
    e.kind = kind; e.due = due; e.view = v;
    e.u = m_cnt[v] % 10; e.t = m_cnt[v] / 10; e.s = m_sat[v];
    e.tu = m_tot % 10; e.tt = m_tot / 10;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops an expectation on every response pulse, checks kind and
  // cycle, then checks the display/total one cycle later.
  initial begin
    exp_t e;
    int kind_seen;
    forever begin
      @(negedge clk);
      if (EN && (sell_ack || sell_err || clr_done)) begin
        kind_seen = clr_done ? 2 : (sell_err ? 1 : 0);
        if (exp_q.size() == 0) begin
          chk("unexpected response pulse", kind_seen + 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("response kind", kind_seen, e.kind);
          chk("response cycle", cyc, e.due);
          @(negedge clk);
          chk("behavior", int'(behavior), e.view);
          chk("sold1", int'(sold1), e.u);
          chk("sold2", int'(sold2), e.t);
          chk("sat", int'(sat), e.s);
          chk("total1", int'(total1), e.tu);
          chk("total2", int'(total2), e.tt);
        end
      end
    end
  end

  task automatic wait_pulse();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sell_ack || sell_err || clr_done) && k < 40);
    if (!(sell_ack || sell_err || clr_done))
      chk("response timeout", int'(sell_ack | sell_err | clr_done), 1);
  endtask

  task automatic sell(input int g, input int q, input int v);
    @(negedge clk);
    sell_good = 3'(g); sell_qty = 2'(q); view_good = 3'(v); sell_req = 1'b1;
    if (g >= 1 && g <= 7 && q >= 1) begin
      m_sell(g, q);
      push(0, cyc + q + 1, v);
    end else begin
      push(1, cyc + 1, v);
    end
    wait_pulse();
    sell_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic view_chk(input int v, input int u, input int t, input int s,
                          input int tu, input int tt);
    @(negedge clk);
    view_good = 3'(v);
    @(negedge clk);
    chk("view sold1", int'(sold1), u);
    chk("view sold2", int'(sold2), t);
    chk("view sat", int'(sat), s);
    chk("view total1", int'(total1), tu);
    chk("view total2", int'(total2), tt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    m_clear();

    // Reset state
    #1;
    chk("reset sell_ack", int'(sell_ack), 0);
    chk("reset sell_err", int'(sell_err), 0);
    chk("reset clr_done", int'(clr_done), 0);
    chk("reset sold", int'({sold2, sold1}), 0);
    chk("reset total", int'({total2, total1}), 0);
    chk("reset behavior", int'(behavior), 0);
    repeat (2) @(negedge clk);
    EN = 1'b1;

    // Basic sale: good 3 qty 2 -> 02
    sell(3, 2, 3);
    view_chk(3, 2, 0, 0, 2, 0);

    // BCD carry: good 5 to 08, then +3 -> 11
    sell(5, 3, 5);
    sell(5, 3, 5);
    sell(5, 2, 5);
    view_chk(5, 8, 0, 0, 0, 1);
    sell(5, 3, 5);
    view_chk(5, 1, 1, 0, 3, 1);

    // Saturation: good 6 to 98, then +3 -> 99 with sat; total pinned at 99
    for (int i = 0; i < 32; i++) sell(6, 3, 6);
    sell(6, 2, 6);
    view_chk(6, 8, 9, 0, 9, 9);
    sell(6, 3, 6);
    view_chk(6, 9, 9, 1, 9, 9);
    view_chk(0, 0, 0, 0, 9, 9);

    // Rejects: good 0, then qty 0; nothing changes
    sell(0, 2, 6);
    sell(4, 0, 4);
    view_chk(3, 2, 0, 0, 9, 9);

    // Clear and sale together: clear wins, then the held sale is serviced
    @(negedge clk);
    sell_good = 3'd2; sell_qty = 2'd1; view_good = 3'd2;
    sell_req = 1'b1; clr_req = 1'b1;
    c = cyc;
    m_clear();
    push(2, c + 8, 2);
    m_sell(2, 1);
    push(0, c + 11, 2);
    wait_pulse();
    clr_req = 1'b0;
    wait_pulse();
    sell_req = 1'b0;
    @(negedge clk);
    view_chk(6, 0, 0, 0, 1, 0);
    view_chk(5, 0, 0, 0, 1, 0);
    view_chk(2, 1, 0, 0, 1, 0);

    // Reset mid-ADD after the first of 3 units: abort, no ack
    @(negedge clk);
    sell_good = 3'd1; sell_qty = 2'd3; view_good = 3'd1; sell_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre-abort total", int'({total2, total1}), 8'h02);
    EN = 1'b0;
    sell_req = 1'b0;
    #1;
    chk("abort sell_ack", int'(sell_ack), 0);
    chk("abort sold", int'({sold2, sold1}), 0);
    chk("abort total", int'({total2, total1}), 0);
    chk("abort behavior", int'(behavior), 0);
    repeat (2) @(negedge clk);
    EN = 1'b1;
    m_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no ack after abort", int'(sell_ack), 0);
    end
    view_chk(1, 0, 0, 0, 0, 0);

    // One more sale after the abort to show the FSM recovered
    sell(7, 1, 7);
    view_chk(7, 1, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    chk("expectations left over", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
